// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared definitions for param_alu_core: MIPS R-type funct codes,
//            control FSM states and the long-operation mode selector.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // MIPS R-type funct codes understood by the core
    localparam logic [5:0] AND_F   = 6'd36;
    localparam logic [5:0] OR_F    = 6'd37;
    localparam logic [5:0] ADD_F   = 6'd32;
    localparam logic [5:0] SUB_F   = 6'd34;
    localparam logic [5:0] SLT_F   = 6'd42;
    localparam logic [5:0] SRL_F   = 6'd2;
    localparam logic [5:0] MULTU_F = 6'd25;
    localparam logic [5:0] DIVU_F  = 6'd27;
    localparam logic [5:0] MFHI_F  = 6'd16;
    localparam logic [5:0] MFLO_F  = 6'd18;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ITER = 1'b1
    } state_e;

    typedef enum logic [0:0] {
        M_MUL = 1'b0,
        M_DIV = 1'b1
    } mode_e;

    // True for the functions that run through the iterative unit
    function automatic logic is_long_op(input logic [5:0] f);
        return (f == MULTU_F) || (f == DIVU_F);
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/seq_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : seq_muldiv
// Purpose  : Iterative unsigned multiplier (shift-add) and restoring divider,
//            one bit per cycle, WIDTH iterations per operation.
// Ports    : clk, reset (async, active-low)
//            start_i   - load operands (issue edge of a MULTU/DIVU)
//            mode_i    - M_MUL / M_DIV, sampled with start_i
//            a_i, b_i  - operands (rs, rt)
//            iter_i    - controller is in its ITER state
//            done_o    - last iteration happens on the coming edge
//            hilo_we_o - write strobe for HI/LO (same as done_o)
//            hi_o/lo_o - HI/LO values to write when hilo_we_o is set
//            err_o     - current operation is a divide by zero
// Revision : 1.0 - initial release
// ============================================================================
module seq_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             start_i,
    input  wire mode_e            mode_i,
    input  wire logic [WIDTH-1:0] a_i,
    input  wire logic [WIDTH-1:0] b_i,
    input  wire logic             iter_i,
    output logic                  done_o,
    output logic                  hilo_we_o,
    output logic [WIDTH-1:0]      hi_o,
    output logic [WIDTH-1:0]      lo_o,
    output logic                  err_o
);

    localparam int CW = $clog2(WIDTH);

    // acc_q/sh_q form one 2*WIDTH shift register:
    //   multiply: {partial product high, multiplier shifting out / product low}
    //   divide  : {partial remainder,    dividend shifting out / quotient in}
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sh_q,  sh_d;
    logic [WIDTH-1:0] opnd_q;           // multiplicand or divisor
    mode_e            mode_q;
    logic             dz_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem;

    always_comb begin
        mul_sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_q, sh_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd_q});
        // When div_ge holds the difference is below the divisor, so the
        // low WIDTH bits are exact.
        div_rem   = div_shift[WIDTH-1:0] - opnd_q;
        if (mode_q == M_MUL) begin
            acc_d = mul_sum[WIDTH:1];
            sh_d  = {mul_sum[0], sh_q[WIDTH-1:1]};
        end else begin
            // Divide by zero needs no special path: every step subtracts 0,
            // so the quotient fills with ones and the remainder ends as A.
            acc_d = div_ge ? div_rem : div_shift[WIDTH-1:0];
            sh_d  = {sh_q[WIDTH-2:0], div_ge};
        end
    end

    assign done_o    = iter_i && (cnt_q == CW'(WIDTH - 1));
    assign hilo_we_o = done_o;
    assign hi_o      = acc_d;
    assign lo_o      = sh_d;
    assign err_o     = dz_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q  <= '0;
            sh_q   <= '0;
            opnd_q <= '0;
            mode_q <= M_MUL;
            dz_q   <= 1'b0;
            cnt_q  <= '0;
        end else if (start_i) begin
            acc_q  <= '0;
            sh_q   <= (mode_i == M_MUL) ? b_i : a_i;
            opnd_q <= (mode_i == M_MUL) ? a_i : b_i;
            mode_q <= mode_i;
            dz_q   <= (mode_i == M_DIV) && (b_i == '0);
            cnt_q  <= '0;
        end else if (iter_i) begin
            acc_q <= acc_d;
            sh_q  <= sh_d;
            cnt_q <= done_o ? '0 : cnt_q + CW'(1);
        end
    end

endmodule : seq_muldiv
`default_nettype wire

// File: rtl/param_alu_core.sv
`default_nettype none
// ============================================================================
// Module   : param_alu_core
// Purpose  : Handshaked MIPS R-type ALU: single-cycle AND/OR/ADD/SUB/SLT/SRL/
//            MFHI/MFLO plus iterative MULTU/DIVU. Owns the HI/LO pair.
// Ports    : clk, reset (async, active-low)
//            in_valid/in_ready   - request handshake (funct, data_a, data_b)
//            out_valid/out_ready - result handshake (result, err)
//            busy                - MULTU/DIVU iteration in progress
// Revision : 1.0 - initial release
// ============================================================================
module param_alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             in_valid,
    output logic                  in_ready,
    input  wire logic [5:0]       funct,
    input  wire logic [WIDTH-1:0] data_a,
    input  wire logic [WIDTH-1:0] data_b,
    output logic                  out_valid,
    input  wire logic             out_ready,
    output logic [WIDTH-1:0]      result,
    output logic                  err,
    output logic                  busy
);

    state_e           state_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             err_q;
    logic [WIDTH-1:0] hi_q, lo_q;

    logic             accept_d;
    logic             long_d;
    mode_e            mode_d;
    logic [WIDTH-1:0] alu_res_d;
    logic             alu_err_d;

    logic             md_done, md_we, md_err;
    logic [WIDTH-1:0] md_hi, md_lo;

    // Gated by reset so the block never advertises ready while held in reset
    assign in_ready  = reset && (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept_d  = in_valid && in_ready;
    assign long_d    = is_long_op(funct);
    assign mode_d    = (funct == DIVU_F) ? M_DIV : M_MUL;

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign err       = err_q;
    assign busy      = (state_q == ITER);

    // Single-cycle functional unit
    always_comb begin
        alu_res_d = '0;
        alu_err_d = 1'b0;
        case (funct)
            AND_F:  alu_res_d = data_a & data_b;
            OR_F:   alu_res_d = data_a | data_b;
            ADD_F:  alu_res_d = data_a + data_b;
            SUB_F:  alu_res_d = data_a - data_b;
            SLT_F:  alu_res_d = {{(WIDTH-1){1'b0}}, ($signed(data_a) < $signed(data_b))};
            SRL_F:  alu_res_d = data_a >> data_b[SHW-1:0];
            MFHI_F: alu_res_d = hi_q;
            MFLO_F: alu_res_d = lo_q;
            default: alu_err_d = 1'b1;  // includes MULTU/DIVU, which never use this path
        endcase
    end

    seq_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk       (clk),
        .reset     (reset),
        .start_i   (accept_d && long_d),
        .mode_i    (mode_d),
        .a_i       (data_a),
        .b_i       (data_b),
        .iter_i    (state_q == ITER),
        .done_o    (md_done),
        .hilo_we_o (md_we),
        .hi_o      (md_hi),
        .lo_o      (md_lo),
        .err_o     (md_err)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            err_q       <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            // Retire first; a load on the same edge overrides, giving
            // back-to-back results without a bubble.
            if (out_ready) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        if (long_d) begin
                            state_q <= ITER;
                        end else begin
                            out_valid_q <= 1'b1;
                            result_q    <= alu_res_d;
                            err_q       <= alu_err_d;
                        end
                    end
                end
                ITER: begin
                    if (md_done) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b1;
                        result_q    <= md_lo;
                        err_q       <= md_err;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (md_we) begin
                hi_q <= md_hi;
                lo_q <= md_lo;
            end
        end
    end

endmodule : param_alu_core
`default_nettype wire
